// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: steers byte lanes onto a valid-ready data bus,
// extends load data, flags misaligned accesses and stalls the core until done.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  pll_1_200MHz,
  input  logic                  pll_1_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic                  lsu_stall,
  output logic [31:0]           load_data,
  output logic                  lsu_done,
  output logic                  lsu_misaligned,
  output logic                  lsu_bus_error,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_byte_en,
  input  logic                  bus_rsp_valid,
  input  logic [31:0]           bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic             access;
  logic             misaligned;
  logic             timeout;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [31:0]      lane_c;
  logic [31:0]      ext_c;

  assign access  = mem_read | mem_write;
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Alignment check, byte enables and lane-replicated store data for the new access
  always_comb begin
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = write_data;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << address[1:0];
        wdata_c = {4{write_data[7:0]}};
      end
      2'b01: begin
        misaligned = address[0];
        be_c       = 4'b0011 << {address[1], 1'b0};
        wdata_c    = {2{write_data[15:0]}};
      end
      default: begin
        misaligned = |address[1:0];
      end
    endcase
  end

  // Lane selection and sign/zero extension of the returned read word
  always_comb begin
    lane_c = bus_rdata >> {off_q, 3'b000};
    ext_c  = bus_rdata;
    case (f3_q[1:0])
      2'b00:   ext_c = f3_q[2] ? {24'd0, lane_c[7:0]}  : {{24{lane_c[7]}}, lane_c[7:0]};
      2'b01:   ext_c = f3_q[2] ? {16'd0, lane_c[15:0]} : {{16{lane_c[15]}}, lane_c[15:0]};
      default: ext_c = bus_rdata;
    endcase
  end

  // Core-facing handshake flags depend on the live request while idle
  assign lsu_misaligned = (state == IDLE) && access && misaligned;
  assign lsu_stall      = ((state == IDLE) && access && !misaligned) ||
                          (state == REQ) || (state == WAIT);

  // Access sequencer with timeout; all bus and result outputs are registered here
  always_ff @(posedge pll_1_200MHz or posedge pll_1_reset) begin
    if (pll_1_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_byte_en   <= '0;
      load_data     <= '0;
      lsu_done      <= 1'b0;
      lsu_bus_error <= 1'b0;
    end else begin
      lsu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (access && !misaligned) begin
            bus_req_valid <= 1'b1;
            bus_we        <= mem_write;
            bus_addr      <= ADDR_WIDTH'({address[31:2], 2'b00});
            bus_byte_en   <= be_c;
            bus_wdata     <= wdata_c;
            f3_q          <= funct3;
            off_q         <= address[1:0];
            cnt           <= '0;
            lsu_bus_error <= 1'b0;
            state         <= REQ;
          end
        end
        REQ: begin
          if (timeout) begin
            bus_req_valid <= 1'b0;
            load_data     <= '0;
            lsu_bus_error <= 1'b1;
            lsu_done      <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (bus_req_ready) begin
              bus_req_valid <= 1'b0;
              state         <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            load_data <= bus_we ? 32'd0 : ext_c;
            lsu_done  <= 1'b1;
            state     <= DONE;
          end else if (timeout) begin
            load_data     <= '0;
            lsu_bus_error <= 1'b1;
            lsu_done      <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          lsu_bus_error <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
